// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants: op classes, opcodes and immediate formats.
package rv32i_pkg;

    // Instruction class as presented on the loader's input stream
    typedef enum logic [3:0] {
        OP_LOAD   = 4'd0,
        OP_STORE  = 4'd1,
        OP_RTYPE  = 4'd2,
        OP_BRANCH = 4'd3,
        OP_ITYPE  = 4'd4,
        OP_JAL    = 4'd5,
        OP_JALR   = 4'd6,
        OP_LUI    = 4'd7,
        OP_AUIPC  = 4'd8
    } op_class_t;

    // 7-bit major opcodes, identical to the main decoder's table
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Immediate layout; FMT_R marks classes that carry no immediate
    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_R
    } imm_fmt_t;

    // Immediate format used by each op class
    function automatic imm_fmt_t fmt_of(logic [3:0] op);
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: return FMT_I;
            OP_STORE:                   return FMT_S;
            OP_BRANCH:                  return FMT_B;
            OP_JAL:                     return FMT_J;
            OP_LUI, OP_AUIPC:           return FMT_U;
            default:                    return FMT_R;
        endcase
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational RV32I encoder: op class plus fields -> machine word and illegal flag.
module instr_encode
    import rv32i_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    imm_fmt_t fmt;
    logic     is_shift;
    logic     fits_12;
    logic     fits_b;
    logic     fits_j;
    logic     imm_ok;

    assign fmt      = fmt_of(op);
    assign is_shift = (op == OP_ITYPE) && (funct3 == 3'b001 || funct3 == 3'b101);
    // Sign-extension checks: all bits above the field's sign bit must agree
    assign fits_12  = (imm[31:11] == '0) || (imm[31:11] == '1);
    assign fits_b   = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    assign fits_j   = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

    // Immediate legality for the selected format
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I:   imm_ok = is_shift ? (imm[31:5] == '0) : fits_12;
            FMT_S:   imm_ok = fits_12;
            FMT_B:   imm_ok = fits_b;
            FMT_J:   imm_ok = fits_j;
            FMT_U:   imm_ok = (imm[11:0] == '0);
            default: imm_ok = 1'b1;
        endcase
    end

    // Field assembly per class; unused fields stay zero
    always_comb begin
        word    = '0;
        illegal = !imm_ok;
        case (op)
            OP_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            OP_ITYPE: begin
                if (is_shift)
                    word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_OP_IMM};
                else
                    word = {imm[11:0], rs1, funct3, rd, OPC_OP_IMM};
            end
            OP_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
            OP_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            OP_RTYPE: begin
                word    = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
                illegal = funct7b5 && !(funct3 == 3'b000 || funct3 == 3'b101);
            end
            OP_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            OP_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            OP_LUI:    word = {imm[31:12], rd, OPC_LUI};
            OP_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams encoded RV32I words into consecutive instruction-memory locations.
module instr_encoder_loader
    import rv32i_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              full,
    output logic              error,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FULL,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              done_next;
    logic              accept;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic [ADDR_W-1:0] target;

    instr_encode u_encode (
        .op       (in_op),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    assign in_ready = (state == S_ACTIVE) && !start && !finish;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_ACTIVE);
    assign full     = (state == S_FULL);
    assign error    = (state == S_ERROR);
    // imem_addr advances only after a write is presented, so a beat accepted
    // while a write is still outstanding lands one slot further on.
    assign target   = imem_we ? imem_addr + 1'b1 : imem_addr;

    // Next-state and done-pulse decode
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (start) begin
                    state_next = S_ACTIVE;
                end else if (finish) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else if (accept) begin
                    if (enc_illegal)
                        state_next = S_ERROR;
                    else if (target == LAST_ADDR)
                        state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (start) begin
                    state_next = S_ACTIVE;
                end else if (finish) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            S_ERROR: begin
                if (start) state_next = S_ACTIVE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, write register, address and word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            imem_we    <= 1'b0;
            imem_wdata <= '0;
            imem_addr  <= BASE;
            count      <= '0;
        end else begin
            state   <= state_next;
            done    <= done_next;
            imem_we <= accept && !enc_illegal;
            if (accept && !enc_illegal)
                imem_wdata <= enc_word;
            // start overrides the post-write increment of an in-flight write
            if (start) begin
                imem_addr <= BASE;
                count     <= '0;
            end else if (imem_we) begin
                if (imem_addr != LAST_ADDR)
                    imem_addr <= imem_addr + 1'b1;
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a 4-word instruction memory.
module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          finish;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [2:0]    in_funct3;
    logic          in_funct7b5;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [31:0]   in_imm;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          full;
    logic          error;
    logic          done;
    logic [AW:0]   count;

    instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .finish      (finish),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .full        (full),
        .error       (error),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        string       tag;
    } bad_t;

    wr_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  exp_addr    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Every presented write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {31'b0, imem_we}, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", {30'b0, imem_addr}, {30'b0, e.addr});
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic legal, input logic [31:0] word,
                        input string tag);
        @(negedge clk);
        in_valid    = 1'b1;
        in_op       = op;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        #1;
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        if (legal) begin
            sb.push_back('{addr: exp_addr[AW-1:0], data: word});
            exp_addr++;
        end
        @(posedge clk);
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = 0;
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        in_valid = 1'b0;
        finish   = 1'b1;
        @(negedge clk);
        finish   = 1'b0;
    endtask

    bad_t bad[$];

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
        in_op = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        check("rst_we",    {31'b0, imem_we},   32'd0);
        check("rst_addr",  {30'b0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata,         32'd0);
        check("rst_busy",  {31'b0, busy},      32'd0);
        check("rst_full",  {31'b0, full},      32'd0);
        check("rst_error", {31'b0, error},     32'd0);
        check("rst_done",  {31'b0, done},      32'd0);
        check("rst_count", {29'b0, count},     32'd0);
        check("rst_ready", {31'b0, in_ready},  32'd0);
        reset = 1'b0;

        // Single addi
        pulse_start();
        check("start_busy", {31'b0, busy}, 32'd1);
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, "addi");
        settle(1);
        check("addi_count", {29'b0, count},     32'd1);
        check("addi_addr",  {30'b0, imem_addr}, 32'd1);

        // Back-to-back stream filling all four words
        pulse_start();
        send(4'd0, 3'b010, 1'b0, 5'd2, 5'd1, 5'd0, 32'd8,  1'b1, 32'h0080A103, "load");
        send(4'd1, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,  1'b1, 32'h0020A223, "store");
        send(4'd3, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 32'hFE208CE3, "branch");
        send(4'd5, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b1, 32'h010000EF, "jal");
        @(negedge clk);
        check("full_flag",  {31'b0, full},     32'd1);
        check("full_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("full_count", {29'b0, count}, 32'd4);
        pulse_finish();
        check("fin_done", {31'b0, done}, 32'd1);
        check("fin_busy", {31'b0, busy}, 32'd0);
        check("fin_full", {31'b0, full}, 32'd0);
        @(negedge clk);
        check("fin_done_pulse", {31'b0, done}, 32'd0);

        // More classes, then an out-of-range immediate
        pulse_start();
        send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, "lui");
        send(4'd2, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h402081B3, "sub");
        send(4'd4, 3'b101, 1'b1, 5'd4, 5'd4, 5'd0, 32'd3,        1'b1, 32'h40325213, "srai");
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h0, "imm2048");
        @(negedge clk);
        check("err_flag",  {31'b0, error},    32'd1);
        check("err_ready", {31'b0, in_ready}, 32'd0);
        check("err_busy",  {31'b0, busy},     32'd0);
        in_op  = 4'd4;
        in_imm = 32'd1;
        repeat (2) @(negedge clk);
        check("err_hold",  {31'b0, error},    32'd1);
        check("err_count", {29'b0, count},    32'd3);
        pulse_start();
        check("clr_error", {31'b0, error},     32'd0);
        check("clr_count", {29'b0, count},     32'd0);
        check("clr_addr",  {30'b0, imem_addr}, 32'd0);

        // Forced funct3 on JALR, AUIPC, I-immediate lower bound
        send(4'd6, 3'b111, 1'b0, 5'd1, 5'd5, 5'd9, -32'sd4,      1'b1, 32'hFFC280E7, "jalr");
        send(4'd8, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFF000, 1'b1, 32'hFFFFF117, "auipc");
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048,   1'b1, 32'h80000093, "imm_min");
        settle(1);
        check("mix_count", {29'b0, count}, 32'd3);

        // Illegal encodings: each must set error without writing
        bad.push_back('{op: 4'd9, f3: 3'b000, f7: 1'b0, imm: 32'd0,         tag: "op9"});
        bad.push_back('{op: 4'd3, f3: 3'b000, f7: 1'b0, imm: -32'sd7,       tag: "b_odd"});
        bad.push_back('{op: 4'd3, f3: 3'b000, f7: 1'b0, imm: 32'd4096,      tag: "b_range"});
        bad.push_back('{op: 4'd7, f3: 3'b000, f7: 1'b0, imm: 32'h12345001,  tag: "u_low"});
        bad.push_back('{op: 4'd5, f3: 3'b000, f7: 1'b0, imm: 32'h00100000,  tag: "j_range"});
        bad.push_back('{op: 4'd4, f3: 3'b001, f7: 1'b0, imm: 32'd32,        tag: "shamt"});
        bad.push_back('{op: 4'd2, f3: 3'b001, f7: 1'b1, imm: 32'd0,         tag: "r_f7"});
        bad.push_back('{op: 4'd1, f3: 3'b010, f7: 1'b0, imm: -32'sd2049,    tag: "s_range"});
        foreach (bad[i]) begin
            pulse_start();
            send(bad[i].op, bad[i].f3, bad[i].f7, 5'd1, 5'd1, 5'd1, bad[i].imm, 1'b0, 32'h0, bad[i].tag);
            @(negedge clk);
            in_valid = 1'b0;
            check({bad[i].tag, "_err"}, {31'b0, error}, 32'd1);
        end

        // start+finish together with a write in flight and a beat offered
        pulse_start();
        send(4'd4, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, "pre_sf");
        @(negedge clk);
        start    = 1'b1;
        finish   = 1'b1;
        in_valid = 1'b1;
        #1;
        check("sf_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        start    = 1'b0;
        finish   = 1'b0;
        in_valid = 1'b0;
        exp_addr = 0;
        check("sf_done",  {31'b0, done},      32'd0);
        check("sf_busy",  {31'b0, busy},      32'd1);
        check("sf_count", {29'b0, count},     32'd0);
        check("sf_addr",  {30'b0, imem_addr}, 32'd0);
        send(4'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, "post_sf");
        settle(1);
        check("post_count", {29'b0, count}, 32'd1);
        pulse_finish();
        check("end_done", {31'b0, done}, 32'd1);

        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        check("drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
